// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for a single-clock show-ahead FIFO.
// Drives the external dual-port memory's write enable and both addresses.
module fifo_ptr_ctrl #(
  parameter int unsigned AW       = 4,
  parameter int unsigned AF_LEVEL = 12,
  parameter int unsigned AE_LEVEL = 4
) (
  input  logic          I_CLK,
  input  logic          I_RST,
  input  logic          I_WR_REQ,
  input  logic          I_RD_REQ,
  output logic          O_MEM_WR_EN,
  output logic [AW-1:0] O_MEM_WR_ADDR,
  output logic [AW-1:0] O_MEM_RD_ADDR,
  output logic          O_FULL,
  output logic          O_EMPTY,
  output logic          O_ALMOST_FULL,
  output logic          O_ALMOST_EMPTY,
  output logic [AW:0]   O_COUNT,
  output logic          O_OVERFLOW,
  output logic          O_UNDERFLOW
);

  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] count;
  logic          wr_acc;
  logic          rd_acc;
  logic          overflow_q;
  logic          underflow_q;

  // Occupancy and flags come straight from the registered pointers; the MSB is the wrap bit.
  assign count   = wr_ptr - rd_ptr;
  assign O_EMPTY = (wr_ptr == rd_ptr);
  assign O_FULL  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign O_COUNT        = count;
  assign O_ALMOST_FULL  = (count >= PW'(AF_LEVEL));
  assign O_ALMOST_EMPTY = (count <= PW'(AE_LEVEL));

  // Write enable is held low during reset so no stale push reaches the memory.
  assign wr_acc = I_WR_REQ & ~O_FULL & ~I_RST;
  assign rd_acc = I_RD_REQ & ~O_EMPTY;

  assign O_MEM_WR_EN   = wr_acc;
  assign O_MEM_WR_ADDR = wr_ptr[AW-1:0];
  assign O_MEM_RD_ADDR = rd_ptr[AW-1:0];
  assign O_OVERFLOW    = overflow_q;
  assign O_UNDERFLOW   = underflow_q;

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
      overflow_q  <= I_WR_REQ & O_FULL;
      underflow_q <= I_RD_REQ & O_EMPTY;
    end
  end

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: behavioural occupancy model, memory model
// and a data scoreboard, plus a table of directed vectors.
module tb_fifo_ptr_ctrl;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 4;

  logic       I_CLK = 1'b0;
  logic       I_RST = 1'b1;
  logic       I_WR_REQ = 1'b0;
  logic       I_RD_REQ = 1'b0;
  logic       O_MEM_WR_EN;
  logic [3:0] O_MEM_WR_ADDR;
  logic [3:0] O_MEM_RD_ADDR;
  logic       O_FULL, O_EMPTY, O_ALMOST_FULL, O_ALMOST_EMPTY;
  logic [4:0] O_COUNT;
  logic       O_OVERFLOW, O_UNDERFLOW;

  fifo_ptr_ctrl #(.AW(4), .AF_LEVEL(12), .AE_LEVEL(4)) dut (
    .I_CLK(I_CLK), .I_RST(I_RST), .I_WR_REQ(I_WR_REQ), .I_RD_REQ(I_RD_REQ),
    .O_MEM_WR_EN(O_MEM_WR_EN), .O_MEM_WR_ADDR(O_MEM_WR_ADDR), .O_MEM_RD_ADDR(O_MEM_RD_ADDR),
    .O_FULL(O_FULL), .O_EMPTY(O_EMPTY), .O_ALMOST_FULL(O_ALMOST_FULL),
    .O_ALMOST_EMPTY(O_ALMOST_EMPTY), .O_COUNT(O_COUNT),
    .O_OVERFLOW(O_OVERFLOW), .O_UNDERFLOW(O_UNDERFLOW)
  );

  always #5 I_CLK = ~I_CLK;

  // Memory model with a combinational read port.
  logic [7:0] mem [DEPTH];
  logic [7:0] wr_data = 8'd0;
  logic [7:0] rd_data;
  assign rd_data = mem[O_MEM_RD_ADDR];
  always @(posedge I_CLK) if (O_MEM_WR_EN) mem[O_MEM_WR_ADDR] <= wr_data;

  int n_checks = 0;
  int n_err    = 0;

  int       m_count = 0;
  int       m_wr_addr = 0;
  int       m_rd_addr = 0;
  bit       m_ovf = 0;
  bit       m_unf = 0;
  int       data_ctr = 0;
  bit [7:0] sb_q[$];

  typedef struct {
    bit wr;
    bit rd;
    bit wr_en;
    int cnt;
    bit ovf;
    bit unf;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, " count"},  int'(O_COUNT), m_count);
    chk({tag, " full"},   int'(O_FULL), int'(m_count == DEPTH));
    chk({tag, " empty"},  int'(O_EMPTY), int'(m_count == 0));
    chk({tag, " afull"},  int'(O_ALMOST_FULL), int'(m_count >= AFL));
    chk({tag, " aempty"}, int'(O_ALMOST_EMPTY), int'(m_count <= AEL));
    chk({tag, " ovf"},    int'(O_OVERFLOW), int'(m_ovf));
    chk({tag, " unf"},    int'(O_UNDERFLOW), int'(m_unf));
    chk({tag, " wraddr"}, int'(O_MEM_WR_ADDR), m_wr_addr);
    chk({tag, " rdaddr"}, int'(O_MEM_RD_ADDR), m_rd_addr);
  endtask

  // One clock: drive at negedge, check pre-edge outputs, update model, check post-edge state.
  task automatic step(input bit wr, input bit rd, input bit rst, output bit got_wr_en);
    bit exp_wr, exp_rd;
    bit [7:0] exp_d;
    @(negedge I_CLK);
    I_WR_REQ = wr;
    I_RD_REQ = rd;
    I_RST    = rst;
    wr_data  = 8'(data_ctr);
    #1;
    exp_wr = wr && !rst && (m_count < DEPTH);
    exp_rd = rd && !rst && (m_count > 0);
    got_wr_en = O_MEM_WR_EN;
    chk("wr_en", int'(O_MEM_WR_EN), int'(exp_wr));
    if (exp_rd) begin
      if (sb_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        exp_d = sb_q.pop_front();
        chk("rd_data", int'(rd_data), int'(exp_d));
      end
    end
    if (exp_wr) begin
      sb_q.push_back(8'(data_ctr));
      data_ctr++;
    end
    if (rst) begin
      m_count = 0; m_wr_addr = 0; m_rd_addr = 0; m_ovf = 0; m_unf = 0;
      sb_q.delete();
    end else begin
      m_ovf = wr && (m_count == DEPTH);
      m_unf = rd && (m_count == 0);
      if (exp_wr) begin m_count++; m_wr_addr = (m_wr_addr + 1) % DEPTH; end
      if (exp_rd) begin m_count--; m_rd_addr = (m_rd_addr + 1) % DEPTH; end
    end
    @(posedge I_CLK);
    #1;
    check_state("post");
  endtask

  initial begin
    bit we;
    bit rolled;
    int prev_rd;
    int rd_before;

    tbl[0]  = '{0, 1, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 1, 1, 0, 1};
    tbl[2]  = '{1, 0, 1, 2, 0, 0};
    tbl[3]  = '{1, 0, 1, 3, 0, 0};
    tbl[4]  = '{1, 0, 1, 4, 0, 0};
    tbl[5]  = '{1, 0, 1, 5, 0, 0};
    tbl[6]  = '{1, 0, 1, 6, 0, 0};
    tbl[7]  = '{1, 0, 1, 7, 0, 0};
    tbl[8]  = '{1, 1, 1, 7, 0, 0};
    tbl[9]  = '{0, 1, 0, 6, 0, 0};
    tbl[10] = '{0, 0, 0, 6, 0, 0};
    tbl[11] = '{0, 1, 0, 5, 0, 0};

    // Reset state
    step(0, 0, 1, we);
    step(0, 0, 1, we);
    chk("rst_count", int'(O_COUNT), 0);
    chk("rst_empty", int'(O_EMPTY), 1);
    chk("rst_aempty", int'(O_ALMOST_EMPTY), 1);
    chk("rst_afull", int'(O_ALMOST_FULL), 0);

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].wr, tbl[i].rd, 0, we);
      chk($sformatf("tbl%0d wr_en", i), int'(we), int'(tbl[i].wr_en));
      chk($sformatf("tbl%0d count", i), int'(O_COUNT), tbl[i].cnt);
      chk($sformatf("tbl%0d ovf", i), int'(O_OVERFLOW), int'(tbl[i].ovf));
      chk($sformatf("tbl%0d unf", i), int'(O_UNDERFLOW), int'(tbl[i].unf));
    end

    // Fill 0..15 from a clean reset
    step(0, 0, 1, we);
    data_ctr = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0, we);
      if (i == 3)  chk("ae_after4", int'(O_ALMOST_EMPTY), 1);
      if (i == 4)  chk("ae_after5", int'(O_ALMOST_EMPTY), 0);
      if (i == 10) chk("af_after11", int'(O_ALMOST_FULL), 0);
      if (i == 11) chk("af_after12", int'(O_ALMOST_FULL), 1);
    end
    chk("full_after16", int'(O_FULL), 1);
    chk("count16", int'(O_COUNT), 16);

    // Push into full: rejected, one-cycle overflow, address 0 untouched
    step(1, 0, 0, we);
    chk("ovf_pulse", int'(O_OVERFLOW), 1);
    chk("mem0_kept", int'(mem[0]), 0);
    step(0, 0, 0, we);
    chk("ovf_cleared", int'(O_OVERFLOW), 0);

    // Drain 16 in order, then an extra pop underflows without moving rd_ptr
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, we);
    chk("empty_after_drain", int'(O_EMPTY), 1);
    rd_before = int'(O_MEM_RD_ADDR);
    step(0, 1, 0, we);
    chk("unf_pulse", int'(O_UNDERFLOW), 1);
    chk("rd_addr_held", int'(O_MEM_RD_ADDR), rd_before);
    step(0, 0, 0, we);
    chk("unf_cleared", int'(O_UNDERFLOW), 0);

    // Simultaneous push/pop at full
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0, we);
    step(1, 1, 0, we);
    chk("sim_full_count", int'(O_COUNT), 15);
    chk("sim_full_ovf", int'(O_OVERFLOW), 1);
    for (int i = 0; i < 15; i++) step(0, 1, 0, we);

    // Wrap: hover at level 3-4 for 40 push/pop pairs
    for (int i = 0; i < 3; i++) step(1, 0, 0, we);
    rolled = 0;
    prev_rd = int'(O_MEM_RD_ADDR);
    for (int i = 0; i < 40; i++) begin
      step(1, 0, 0, we);
      step(0, 1, 0, we);
      if (prev_rd == 15 && int'(O_MEM_RD_ADDR) == 0) rolled = 1;
      prev_rd = int'(O_MEM_RD_ADDR);
    end
    chk("rd_addr_rolled", int'(rolled), 1);

    // Reset mid-stream at count 9 with both requests high
    for (int i = 0; i < 6; i++) step(1, 0, 0, we);
    chk("pre_reset_count", int'(O_COUNT), 9);
    step(1, 1, 1, we);
    chk("rst_wr_en_low", int'(we), 0);
    chk("mid_rst_count", int'(O_COUNT), 0);
    chk("mid_rst_empty", int'(O_EMPTY), 1);
    chk("mid_rst_ovf", int'(O_OVERFLOW), 0);
    chk("mid_rst_unf", int'(O_UNDERFLOW), 0);
    step(0, 0, 0, we);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
